dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port round-robin arbiter and access sequencer in front of the single-port data memory.
- Port 0 is the CPU load/store unit. Port 1 is the debug/loader master.
- Serialises requests onto the memory's combinational-read / synchronous-write port and checks alignment and range.
- Returns registered read data or an error flag with fixed 1-cycle latency.

Parameters:
- MEMORY_SIZE, 2048: data memory size in bytes. Addresses at or above this value are out of range.
- ADDR_W, 32: request address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-port request valid; bit i belongs to port i.
- req_ready  out  2  per-port accept; a request transfers when valid and ready are both high.
- req_addr  in  2x32  per-port byte address.
- req_wdata  in  2x32  per-port write data, byte-lane aligned.
- req_mask  in  2x4  per-port byte mask. Legal values: 0001, 0011, 1111.
- req_we  in  2  per-port write enable: 1 = store, 0 = load.
- resp_valid  out  2  per-port 1-cycle response pulse.
- resp_rdata  out  32  registered load data. Zero for stores and for errors.
- resp_err  out  1  qualifies resp_valid; 1 = access rejected.
- mem_addr  out  32  to memory address input.
- mem_write_data  out  32  to memory write data input.
- mem_data_mask  out  4  to memory byte mask input.
- mem_write_en  out  1  to memory write enable.
- mem_read_en  out  1  to memory read enable.
- mem_read_data  in  32  from memory; combinational read of mem_addr.

Behaviour:
- Reset values: req_ready=00, resp_valid=00, resp_rdata=0, resp_err=0, all mem_* outputs=0, last_grant=1. With last_grant=1, port 0 wins the first conflict.
- Arbitration (combinational, every cycle):
  - Only port 0 valid: grant 0.
  - Only port 1 valid: grant 1.
  - Both valid: grant the port != last_grant.
  - At most one req_ready bit is high. req_ready is 00 while rst=1.
- Accept cycle (valid & ready on the granted port):
  - mem_addr, mem_write_data, mem_data_mask and mem_write_en/mem_read_en are driven from the granted port in the same cycle.
  - A store commits at the next clk edge.
  - For a load, mem_read_data is captured into resp_rdata at the same edge.
  - last_grant is updated to the granted port at that edge.
- Error check (combinational):
  - Misaligned access: mask 0011 with addr[0]=1, or mask 1111 with addr[1:0]!=00.
  - Illegal mask value.
  - addr >= MEMORY_SIZE.
  - On error: request is still accepted (ready=1) but mem_write_en=0 and mem_read_en=0. The response carries resp_err=1 and resp_rdata=0.
- Response:
  - resp_valid[g] pulses for exactly one cycle, the cycle after acceptance.
  - resp_err is valid with that pulse. resp_rdata is valid with that pulse for loads.
  - No backpressure on responses: requesters must sample the response in that cycle.
- Throughput:
  - One accept per cycle, so back-to-back requests are allowed.
  - A response and a new acceptance may occur in the same cycle.
  - Under continuous contention the ports alternate strictly (0,1,0,1...).
- Idle: when no request is accepted, mem_write_en=0, mem_read_en=0, mem_addr holds 0, and the memory sees no access.
- Stability: a requester holds addr/wdata/mask/we stable while valid=1 and ready=0. The block does not check this.
- Reset mid-operation:
  - A pending response is dropped: resp_valid=00 on the next cycle.
  - A store that was accepted in the cycle rst is sampled is suppressed, because mem_write_en is gated by !rst.
  - last_grant returns to 1.
- Load data extraction: byte and halfword extraction is done by the memory from mem_data_mask and addr[1:0]. This block passes resp_rdata through unmodified.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_grant0, perf_grant1, perf_conflict and perf_err, each 32 bits.
  - perf_grant0 / perf_grant1 increment on each accepted request from port 0 / port 1.
  - perf_conflict increments each cycle both req_valid bits are high.
  - perf_err increments on each error response.
  - All counters reset to 0 on rst, wrap modulo 2^32 and saturate never.
- Undefined: these ports and registers do not exist, and behaviour is otherwise identical.

Test Plan:
- Port 0 store addr=0x10, wdata=0xDEADBEEF, mask=1111, then port 0 load addr=0x10 -> second response resp_valid=01, resp_err=0, resp_rdata=0xDEADBEEF, one cycle after accept.
- Both ports issue a load every cycle for 6 cycles after reset -> accept order 0,1,0,1,0,1; each resp_valid bit pulses on alternate cycles; req_ready is never 11.
- Port 1 load addr=0x13, mask=1111 -> accepted, mem_read_en=0, next cycle resp_valid=10, resp_err=1, resp_rdata=0.
- Port 0 store addr=0x800 (=MEMORY_SIZE) -> resp_err=1, mem_write_en never asserted, memory unchanged.
- Port 0 store byte addr=0x21, wdata=0x0000AB00, mask=0001, then load addr=0x21, mask=0001 -> resp_rdata=0x000000AB.
- Assert rst in the cycle after a port 1 load is accepted -> resp_valid stays 00; after release, simultaneous requests grant port 0 first.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-port round-robin arbiter and access sequencer in front of the single-port
// data memory. Port 0 is the CPU load/store unit, port 1 the debug/loader
// master. One request is accepted per cycle. The accepted request is driven
// onto the memory port in the same cycle. Its response (load data or error)
// appears exactly one cycle later as a single-cycle pulse.
//
// Optional build macro: DMEM_ARB_PERF_EN adds four 32-bit event counters.
//
// Ports:
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   req_valid[1:0]  per-port request valid
//   req_ready[1:0]  per-port accept (at most one bit high)
//   req_addr[p]     per-port byte address
//   req_wdata[p]    per-port write data, byte-lane aligned
//   req_mask[p]     per-port byte mask (0001, 0011 or 1111)
//   req_we[1:0]     per-port write enable (1 = store, 0 = load)
//   resp_valid[1:0] per-port one-cycle response pulse
//   resp_rdata      registered load data (zero for stores and errors)
//   resp_err        qualifies resp_valid, 1 = access rejected
//   mem_*           combinational-read / synchronous-write memory port
//   perf_*          event counters (only with DMEM_ARB_PERF_EN)
// -----------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter #(
    parameter int MEMORY_SIZE = 2048,
    parameter int ADDR_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][31:0]       req_wdata,
    input  logic [1:0][3:0]        req_mask,
    input  logic [1:0]             req_we,
    output logic [1:0]             resp_valid,
    output logic [31:0]            resp_rdata,
    output logic                   resp_err,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [31:0]            mem_write_data,
    output logic [3:0]             mem_data_mask,
    output logic                   mem_write_en,
    output logic                   mem_read_en,
    input  logic [31:0]            mem_read_data
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]            perf_grant0,
    output logic [31:0]            perf_grant1,
    output logic [31:0]            perf_conflict,
    output logic [31:0]            perf_err
`endif
);

    // Returns 1 when the access must be rejected: illegal mask, misaligned
    // halfword/word, or address beyond the end of the memory.
    function automatic logic access_err(input logic [ADDR_W-1:0] addr,
                                        input logic [3:0]        mask);
        logic bad_s;
        case (mask)
            4'b0001: bad_s = 1'b0;
            4'b0011: bad_s = addr[0];
            4'b1111: bad_s = (addr[1:0] != 2'b00);
            default: bad_s = 1'b1;
        endcase
        return bad_s || (addr >= ADDR_W'(MEMORY_SIZE));
    endfunction

    logic        last_grant_r;
    logic        grant_s;
    logic        accept_s;
    logic        sel_err_s;
    logic [1:0]  resp_valid_r;
    logic [31:0] resp_rdata_r;
    logic        resp_err_r;

    // Round-robin arbitration: on contention the port that did not win last
    // time is granted. Nothing is granted while reset is held.
    always_comb begin
        grant_s  = 1'b0;
        accept_s = 1'b0;
        if (rst) begin
            grant_s  = 1'b0;
            accept_s = 1'b0;
        end else begin
            case (req_valid)
                2'b01: begin
                    grant_s  = 1'b0;
                    accept_s = 1'b1;
                end
                2'b10: begin
                    grant_s  = 1'b1;
                    accept_s = 1'b1;
                end
                2'b11: begin
                    grant_s  = ~last_grant_r;
                    accept_s = 1'b1;
                end
                default: begin
                    grant_s  = 1'b0;
                    accept_s = 1'b0;
                end
            endcase
        end
    end

    // Ready is only raised on the granted port, so a grant is an acceptance.
    always_comb begin
        req_ready = 2'b00;
        if (accept_s) begin
            req_ready = grant_s ? 2'b10 : 2'b01;
        end else begin
            req_ready = 2'b00;
        end
    end

    // Error check on the granted request.
    always_comb begin
        sel_err_s = access_err(req_addr[grant_s], req_mask[grant_s]);
    end

    // Memory port drive: the granted request goes straight to the memory;
    // rejected requests keep both enables low so the memory is not touched.
    // The write enable is additionally gated by reset.
    always_comb begin
        mem_addr       = '0;
        mem_write_data = 32'd0;
        mem_data_mask  = 4'd0;
        mem_write_en   = 1'b0;
        mem_read_en    = 1'b0;
        if (accept_s) begin
            mem_addr       = req_addr[grant_s];
            mem_write_data = req_wdata[grant_s];
            mem_data_mask  = req_mask[grant_s];
            mem_write_en   = req_we[grant_s] & ~sel_err_s & ~rst;
            mem_read_en    = ~req_we[grant_s] & ~sel_err_s;
        end else begin
            mem_addr       = '0;
            mem_write_data = 32'd0;
            mem_data_mask  = 4'd0;
            mem_write_en   = 1'b0;
            mem_read_en    = 1'b0;
        end
    end

    // Grant history and the registered one-cycle response.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= 1'b1;
            resp_valid_r <= 2'b00;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
        end else if (accept_s) begin
            last_grant_r <= grant_s;
            resp_valid_r <= grant_s ? 2'b10 : 2'b01;
            resp_err_r   <= sel_err_s;
            resp_rdata_r <= mem_read_en ? mem_read_data : 32'd0;
        end else begin
            last_grant_r <= last_grant_r;
            resp_valid_r <= 2'b00;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'd0;
        end
    end

    // Response outputs are forced quiet while reset is held so that a pending
    // response is dropped in the reset cycle itself.
    always_comb begin
        if (rst) begin
            resp_valid = 2'b00;
            resp_rdata = 32'd0;
            resp_err   = 1'b0;
        end else begin
            resp_valid = resp_valid_r;
            resp_rdata = resp_rdata_r;
            resp_err   = resp_err_r;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_grant0_r;
    logic [31:0] perf_grant1_r;
    logic [31:0] perf_conflict_r;
    logic [31:0] perf_err_r;

    // Free-running event counters; they wrap and never saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grant0_r   <= 32'd0;
            perf_grant1_r   <= 32'd0;
            perf_conflict_r <= 32'd0;
            perf_err_r      <= 32'd0;
        end else begin
            perf_grant0_r   <= perf_grant0_r + {31'd0, accept_s & ~grant_s};
            perf_grant1_r   <= perf_grant1_r + {31'd0, accept_s & grant_s};
            perf_conflict_r <= perf_conflict_r + {31'd0, (req_valid == 2'b11)};
            perf_err_r      <= perf_err_r + {31'd0, (resp_valid_r != 2'b00) & resp_err_r};
        end
    end

    assign perf_grant0   = perf_grant0_r;
    assign perf_grant1   = perf_grant1_r;
    assign perf_conflict = perf_conflict_r;
    assign perf_err      = perf_err_r;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Scoreboard bench. A driver feeds per-port request queues to the DUT. A
// reference model (byte-addressed memory, round-robin rule, error rules)
// predicts the grant every cycle and pushes the expected response. A separate
// monitor pops and compares responses when the DUT presents them. A simple
// word-organised memory model sits on the DUT memory port.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
    localparam int MEMORY_SIZE = 2048;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        we;
        logic        idle;
    } req_t;

    typedef struct packed {
        logic [1:0]  port;
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req_valid = 2'b00;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_addr = '0;
    logic [1:0][31:0] req_wdata = '0;
    logic [1:0][3:0]  req_mask = '0;
    logic [1:0]       req_we = 2'b00;
    logic [1:0]       resp_valid;
    logic [31:0]      resp_rdata;
    logic             resp_err;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_write_data;
    logic [3:0]       mem_data_mask;
    logic             mem_write_en;
    logic             mem_read_en;
    logic [31:0]      mem_read_data;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0]      perf_grant0, perf_grant1, perf_conflict, perf_err;
`endif

    dmem_arbiter #(.MEMORY_SIZE(MEMORY_SIZE), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_mask(req_mask), .req_we(req_we),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_data_mask(mem_data_mask), .mem_write_en(mem_write_en),
        .mem_read_en(mem_read_en), .mem_read_data(mem_read_data)
`ifdef DMEM_ARB_PERF_EN
        , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1)
        , .perf_conflict(perf_conflict), .perf_err(perf_err)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- memory on the DUT memory port ----------------
    logic [31:0] sim_mem [0:MEMORY_SIZE/4-1] = '{default: 32'd0};
    logic [31:0] word_s;
    logic [3:0]  lane_s;
    assign word_s = sim_mem[mem_addr[10:2]];
    assign lane_s = 4'(mem_data_mask << mem_addr[1:0]);
    assign mem_read_data = (word_s >> {mem_addr[1:0], 3'b000}) &
        {{8{mem_data_mask[3]}}, {8{mem_data_mask[2]}}, {8{mem_data_mask[1]}}, {8{mem_data_mask[0]}}};

    always @(posedge clk) begin
        if (mem_write_en) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_s[k]) sim_mem[mem_addr[10:2]][8*k +: 8] <= mem_write_data[8*k +: 8];
            end
        end
    end

    // ---------------- bench state ----------------
    logic [7:0] model_mem [0:MEMORY_SIZE-1] = '{default: 8'd0};
    req_t pq [2][$];
    exp_t sb [$];
    int   acc_cnt [2] = '{0, 0};
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic req_t mk(input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] m, input logic w);
        req_t r;
        r.addr = a; r.wdata = d; r.mask = m; r.we = w; r.idle = 1'b0;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        int   k;
        k = int'($urandom_range(0, 9));
        if (k < 3)      r.mask = 4'b0001;
        else if (k < 6) r.mask = 4'b0011;
        else if (k < 9) r.mask = 4'b1111;
        else            r.mask = 4'($urandom_range(0, 15));
        r.addr = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 5) != 0) begin
            if (r.mask == 4'b0011)      r.addr[0] = 1'b0;
            else if (r.mask == 4'b1111) r.addr[1:0] = 2'b00;
        end
        k = int'($urandom_range(0, 19));
        if (k == 0)      r.addr = 32'(MEMORY_SIZE) + 32'($urandom_range(0, 3)) * 32'd4;
        else if (k == 1) r.addr = $urandom() | 32'h8000_0000;
        else if (k == 2) r.addr = 32'(MEMORY_SIZE - 4);
        r.wdata = $urandom();
        r.we    = 1'($urandom_range(0, 1));
        r.idle  = ($urandom_range(0, 3) == 0);
        return r;
    endfunction

    // cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // driver: presents the head of each port queue, pops it once accepted
    initial begin : driver
        int seen [2];
        bit idl [2];
        seen = '{0, 0};
        idl  = '{1'b0, 1'b0};
        forever begin
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                if ((acc_cnt[p] != seen[p] || idl[p]) && pq[p].size() > 0) void'(pq[p].pop_front());
                seen[p] = acc_cnt[p];
                idl[p]  = 1'b0;
                if (pq[p].size() > 0 && pq[p][0].idle) begin
                    req_valid[p] = 1'b0;
                    idl[p]       = 1'b1;
                end else if (pq[p].size() > 0) begin
                    req_valid[p] = 1'b1;
                    req_addr[p]  = pq[p][0].addr;
                    req_wdata[p] = pq[p][0].wdata;
                    req_mask[p]  = pq[p][0].mask;
                    req_we[p]    = pq[p][0].we;
                end else begin
                    req_valid[p] = 1'b0;
                end
            end
        end
    end

    // reference model: grant rule, error rules, byte memory, expected response
    initial begin : model
        int          lg, g, sz;
        logic [31:0] a, d, rd;
        logic [3:0]  m;
        logic        w, err;
        exp_t        e;
        lg = 1;
        forever begin
            @(negedge clk);
            if (rst) begin
                lg = 1;
                chk("ready_in_reset", 32'(req_ready), 32'd0);
                chk("mem_en_in_reset", {30'd0, mem_write_en, mem_read_en}, 32'd0);
            end else begin
                g = -1;
                if (req_valid == 2'b01)      g = 0;
                else if (req_valid == 2'b10) g = 1;
                else if (req_valid == 2'b11) g = (lg == 1) ? 0 : 1;
                chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
                if (g >= 0) begin
                    a  = req_addr[g];
                    d  = req_wdata[g];
                    m  = req_mask[g];
                    w  = req_we[g];
                    sz = (m == 4'b0001) ? 1 : (m == 4'b0011) ? 2 : (m == 4'b1111) ? 4 : 0;
                    err = (sz == 0) || ((a % sz) != 0) || (a >= 32'(MEMORY_SIZE));
                    rd = 32'd0;
                    if (!err && !w) begin
                        for (int i = 0; i < sz; i++) rd[8*i +: 8] = model_mem[int'(a) + i];
                    end
                    if (!err && w) begin
                        for (int i = 0; i < sz; i++) model_mem[int'(a) + i] = d[8*((int'(a) + i) % 4) +: 8];
                    end
                    chk("mem_write_en", 32'(mem_write_en), 32'(w && !err));
                    chk("mem_read_en", 32'(mem_read_en), 32'(!w && !err));
                    if (!err) chk("mem_addr", mem_addr, a);
                    e.port  = 2'(g);
                    e.err   = err;
                    e.rdata = rd;
                    e.due   = cyc + 1;
                    sb.push_back(e);
                    lg = g;
                    acc_cnt[g]++;
                end else begin
                    chk("idle_mem", {mem_addr[29:0], mem_write_en, mem_read_en}, 32'd0);
                end
            end
        end
    end

    // monitor: compares every DUT response against the scoreboard
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("resp_valid_in_reset", 32'(resp_valid), 32'd0);
                sb.delete();
            end else if (resp_valid != 2'b00 || (sb.size() > 0 && sb[0].due == cyc)) begin
                if (sb.size() == 0 || sb[0].due != cyc) begin
                    chk("unexpected_resp", 32'(resp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_valid", 32'(resp_valid), (e.port == 2'd0) ? 32'd1 : 32'd2);
                    chk("resp_err", 32'(resp_err), 32'(e.err));
                    chk("resp_rdata", resp_rdata, e.rdata);
                end
            end else begin
                chk("resp_idle", 32'(resp_valid), 32'd0);
            end
        end
    end

    task automatic drain(input string nm, input int limit);
        bit done;
        done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            @(posedge clk);
            #3;
            done = (pq[0].size() == 0) && (pq[1].size() == 0) && (sb.size() == 0);
        end
        chk({"drain_", nm}, 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #2; rst = 1'b1;
        repeat (2) @(posedge clk);
        #2; rst = 1'b0;
    endtask

    initial begin : main
        int a0;
        bit got;
        repeat (3) @(posedge clk);
        #2; rst = 1'b0;

        // store then load back a full word
        pq[0].push_back(mk(32'h10, 32'hDEADBEEF, 4'b1111, 1'b1));
        pq[0].push_back(mk(32'h10, 32'h0, 4'b1111, 1'b0));
        drain("store_load", 50);

        // continuous contention from reset: strict alternation 0,1,0,1...
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pq[0].push_back(mk(32'(8 * i), 32'h0, 4'b1111, 1'b0));
            pq[1].push_back(mk(32'(8 * i + 4), 32'h0, 4'b1111, 1'b0));
        end
        drain("contention", 50);

        // misaligned word load, out-of-range store, illegal mask
        pq[1].push_back(mk(32'h13, 32'h0, 4'b1111, 1'b0));
        pq[0].push_back(mk(32'h800, 32'h12345678, 4'b1111, 1'b1));
        pq[0].push_back(mk(32'h0, 32'h0, 4'b1111, 1'b0));
        pq[1].push_back(mk(32'h4, 32'h0, 4'b0111, 1'b0));
        pq[1].push_back(mk(32'h7FC, 32'hCAFEF00D, 4'b1111, 1'b1));
        pq[1].push_back(mk(32'h7FC, 32'h0, 4'b1111, 1'b0));
        drain("errors", 50);

        // byte store into lane 1, byte load back
        pq[0].push_back(mk(32'h21, 32'h0000AB00, 4'b0001, 1'b1));
        pq[0].push_back(mk(32'h21, 32'h0, 4'b0001, 1'b0));
        pq[1].push_back(mk(32'h22, 32'h5A5A0000, 4'b0011, 1'b1));
        pq[1].push_back(mk(32'h20, 32'h0, 4'b1111, 1'b0));
        drain("byte_half", 50);

        // reset in the cycle after a port 1 load is accepted
        a0 = acc_cnt[1];
        pq[1].push_back(mk(32'h10, 32'h0, 4'b1111, 1'b0));
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (acc_cnt[1] != a0);
        end
        chk("accept_before_reset", 32'(got), 32'd1);
        @(posedge clk); #2; rst = 1'b1;
        pq[0].push_back(mk(32'h10, 32'h0, 4'b1111, 1'b0));
        pq[1].push_back(mk(32'h14, 32'h0, 4'b1111, 1'b0));
        repeat (2) @(posedge clk);
        #2; rst = 1'b0;
        drain("after_reset", 50);

        // randomized traffic with occasional reset pulses
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #2;
            rst = ($urandom_range(0, 99) == 0);
            for (int p = 0; p < 2; p++) begin
                if (pq[p].size() < 2) pq[p].push_back(rand_req());
            end
        end
        @(posedge clk); #2; rst = 1'b0;
        drain("random", 500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule
